// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe
// Two-stage radix-2 FFT butterfly: out0 = A + B, out1 = A - B per I/Q
// component, with per-sample divide-by-2 (round half up) and a sticky
// overflow flag for unscaled results that do not fit in W bits.
// Optional feature macro: BUTTERFLY_R2_SAT_EN
//   defined   -> unscaled overflow saturates to the nearest W-bit bound
//   undefined -> unscaled overflow wraps (low W bits kept)
// o_ovf behaves identically in both builds.

module butterfly_r2_pipe #(
    parameter int DATA_FFT_SIZE = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic                     i_scale,
    input  logic [DATA_FFT_SIZE-1:0] i_data_in0_i,
    input  logic [DATA_FFT_SIZE-1:0] i_data_in0_q,
    input  logic [DATA_FFT_SIZE-1:0] i_data_in1_i,
    input  logic [DATA_FFT_SIZE-1:0] i_data_in1_q,
    input  logic                     i_ovf_clr,
    output logic                     o_valid,
    output logic [DATA_FFT_SIZE-1:0] o_data_out0_i,
    output logic [DATA_FFT_SIZE-1:0] o_data_out0_q,
    output logic [DATA_FFT_SIZE-1:0] o_data_out1_i,
    output logic [DATA_FFT_SIZE-1:0] o_data_out1_q,
    output logic                     o_ovf
);

    localparam int W = DATA_FFT_SIZE;

    // Stage-1 registers: full-precision (W+1 bit) sums/differences
    logic         v1;
    logic         sc1;
    logic [W:0]   sum_i;
    logic [W:0]   sum_q;
    logic [W:0]   diff_i;
    logic [W:0]   diff_q;

    // Stage-2 combinational results
    logic [W-1:0] red_sum_i;
    logic [W-1:0] red_sum_q;
    logic [W-1:0] red_diff_i;
    logic [W-1:0] red_diff_q;
    logic         any_ovf;

    // Sign-extended operands
    logic [W:0]   a_i;
    logic [W:0]   a_q;
    logic [W:0]   b_i;
    logic [W:0]   b_q;

    assign a_i = {i_data_in0_i[W-1], i_data_in0_i};
    assign a_q = {i_data_in0_q[W-1], i_data_in0_q};
    assign b_i = {i_data_in1_i[W-1], i_data_in1_i};
    assign b_q = {i_data_in1_q[W-1], i_data_in1_q};

    // An unscaled W+1 bit value fits in W bits only if its top two bits agree
    function automatic logic does_overflow(input logic [W:0] x);
        does_overflow = (x[W] != x[W-1]);
    endfunction

    // Reduce a W+1 bit value to W bits: halve with round-half-up, or
    // truncate with wrap/saturate handling when the value does not fit
    function automatic logic [W-1:0] reduce_value(input logic [W:0] x,
                                                  input logic       scale);
        logic [W:0] rounded;
        rounded = x + {{W{1'b0}}, 1'b1};
        if (scale) begin
            // arithmetic shift right by one keeps the low W bits of rounded[W:1]
            reduce_value = rounded[W:1];
        end else if (does_overflow(x)) begin
`ifdef BUTTERFLY_R2_SAT_EN
            reduce_value = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
            reduce_value = x[W-1:0];
`endif
        end else begin
            reduce_value = x[W-1:0];
        end
    endfunction

    // Stage 1: form sum and difference; data only captured on valid input
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1     <= 1'b0;
            sc1    <= 1'b0;
            sum_i  <= '0;
            sum_q  <= '0;
            diff_i <= '0;
            diff_q <= '0;
        end else if (i_en) begin
            v1 <= i_valid;
            if (i_valid) begin
                sc1    <= i_scale;
                sum_i  <= a_i + b_i;
                sum_q  <= a_q + b_q;
                diff_i <= a_i - b_i;
                diff_q <= a_q - b_q;
            end
        end
    end

    // Stage 2 combinational reduction and overflow detection
    always_comb begin
        red_sum_i  = reduce_value(sum_i,  sc1);
        red_sum_q  = reduce_value(sum_q,  sc1);
        red_diff_i = reduce_value(diff_i, sc1);
        red_diff_q = reduce_value(diff_q, sc1);
        any_ovf    = !sc1 && (does_overflow(sum_i)  || does_overflow(sum_q) ||
                              does_overflow(diff_i) || does_overflow(diff_q));
    end

    // Stage 2 output registers; data hold their last value when no sample arrives
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_data_out0_i <= '0;
            o_data_out0_q <= '0;
            o_data_out1_i <= '0;
            o_data_out1_q <= '0;
        end else if (i_en) begin
            o_valid <= v1;
            if (v1) begin
                o_data_out0_i <= red_sum_i;
                o_data_out0_q <= red_sum_q;
                o_data_out1_i <= red_diff_i;
                o_data_out1_q <= red_diff_q;
            end
        end
    end

    // Sticky overflow flag: a fresh overflow beats a simultaneous clear,
    // and the clear acts even while the pipeline is stalled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
        end else if (i_en && v1 && any_ovf) begin
            o_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            o_ovf <= 1'b0;
        end
    end

endmodule
